// File: rtl/i2s_fir_pkg.sv
// Shared types, default coefficient table and width helpers for the TDM FIR.
package i2s_fir_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    MAC,
    ROUND,
    OUT
  } fir_state_e;

  localparam int DEF_TAPS = 31;

  // Symmetric 31-tap low-pass, Q1.15: ends -230, centre 3960.
  localparam logic signed [15:0] DEF_COEF [DEF_TAPS] = '{
    -16'sd230, -16'sd242, -16'sd236, -16'sd198, -16'sd120,  16'sd0,
     16'sd164,  16'sd372,  16'sd620,  16'sd906,  16'sd1222, 16'sd1562,
     16'sd2000, 16'sd2700, 16'sd3400, 16'sd3960, 16'sd3400, 16'sd2700,
     16'sd2000, 16'sd1562, 16'sd1222, 16'sd906,  16'sd620,  16'sd372,
     16'sd164,  16'sd0,   -16'sd120, -16'sd198, -16'sd236, -16'sd242,
    -16'sd230
  };

  // Default tap value; taps beyond the built-in table start at zero.
  function automatic logic signed [15:0] default_coef(input int k);
    if (k >= 0 && k < DEF_TAPS) return DEF_COEF[k];
    return 16'sd0;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift and clip to OUT_W bits with a clip flag.
module fir_round_sat #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  // One extra bit keeps the rounding add from wrapping.
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [IN_W:0] MAXV = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] shifted;

  // Round, scale, then clip against the output range.
  always_comb begin
    sum     = {acc[IN_W-1], acc} + HALF;
    shifted = sum >>> SHIFT;
    y       = shifted[OUT_W-1:0];
    sat     = 1'b0;
    if (shifted > MAXV) begin
      y   = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      y   = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/i2s_fir_tdm.sv
// Time-multiplexed FIR: one MAC shared by NUM_CH interleaved channels, loadable taps.
module i2s_fir_tdm
  import i2s_fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 31,
  parameter int NUM_CH     = 2,
  parameter int GAIN_SHIFT = 15,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                              sck,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [width_of(NUM_CH)-1:0]       in_ch,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic                              bypass,
  input  logic                              coef_we,
  input  logic [width_of(NUM_TAPS)-1:0]     coef_addr,
  input  logic [COEF_WIDTH-1:0]             coef_wdata,
  output logic                              coef_err,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [width_of(NUM_CH)-1:0]       out_ch,
  output logic                              out_vld,
  output logic                              sat
);

  localparam int CH_W     = width_of(NUM_CH);
  localparam int TAP_W    = width_of(NUM_TAPS);
  localparam int CH_SLOTS = 1 << CH_W;
  localparam int DL_DEPTH = NUM_CH * NUM_TAPS;
  localparam int DL_AW    = width_of(DL_DEPTH);
  localparam int PROD_W   = DATA_WIDTH + COEF_WIDTH;

  fir_state_e state_reg, state_next;

  logic [DL_AW-1:0]             cnt_reg;
  logic [TAP_W-1:0]             wptr_reg [CH_SLOTS];
  logic [CH_W-1:0]              ch_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic [DATA_WIDTH-1:0]        res_reg;
  logic                         sat_res_reg;

  logic signed [DATA_WIDTH-1:0] dl_mem [DL_DEPTH];
  logic signed [COEF_WIDTH-1:0] cf_mem [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] x_rd;
  logic signed [COEF_WIDTH-1:0] h_rd;

  logic                         dl_we, cf_we;
  logic [DL_AW-1:0]             dl_addr, rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0]        dl_wdata;
  logic [TAP_W-1:0]             cf_addr, tap_idx, rd_ptr;
  logic [TAP_W:0]               ptr_sum;
  logic [COEF_WIDTH-1:0]        cf_wdata;
  logic                         ch_ok, accept, coef_ok;

  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, acc_sum;
  logic signed [DATA_WIDTH-1:0] rs_y;
  logic                         rs_sat;

  assign in_rdy   = (state_reg == IDLE);
  assign tap_idx  = cnt_reg[TAP_W-1:0];
  assign ch_ok    = {1'b0, in_ch} < (CH_W+1)'(NUM_CH);
  assign accept   = in_rdy && in_vld && ch_ok;
  assign coef_ok  = coef_we && in_rdy && ({1'b0, coef_addr} < (TAP_W+1)'(NUM_TAPS));
  assign prod     = x_rd * h_rd;
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_sum  = acc_reg + prod_ext;

  fir_round_sat #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (DATA_WIDTH),
    .SHIFT (GAIN_SHIFT)
  ) u_round_sat (
    .acc (acc_sum),
    .y   (rs_y),
    .sat (rs_sat)
  );

  // Delay-line read pointer: newest sample minus tap index, wrapped per channel.
  always_comb begin
    ptr_sum = {1'b0, wptr_reg[ch_reg]} + (TAP_W+1)'(NUM_TAPS) - {1'b0, tap_idx};
    if (ptr_sum >= (TAP_W+1)'(NUM_TAPS)) ptr_sum = ptr_sum - (TAP_W+1)'(NUM_TAPS);
    rd_ptr  = ptr_sum[TAP_W-1:0];
    rd_addr = DL_AW'(int'(ch_reg) * NUM_TAPS + int'(rd_ptr));
    wr_addr = DL_AW'(int'(in_ch) * NUM_TAPS + int'(wptr_reg[in_ch]));
  end

  // State register.
  always_ff @(posedge sck) begin
    if (!rst_n) state_reg <= INIT;
    else        state_reg <= state_next;
  end

  // Next state and RAM port control.
  always_comb begin
    state_next = state_reg;
    dl_we      = 1'b0;
    dl_addr    = rd_addr;
    dl_wdata   = in_data;
    cf_we      = 1'b0;
    cf_addr    = tap_idx;
    cf_wdata   = coef_wdata;
    case (state_reg)
      INIT: begin
        dl_we    = 1'b1;
        dl_addr  = cnt_reg;
        dl_wdata = '0;
        cf_we    = (int'(cnt_reg) < NUM_TAPS);
        cf_addr  = cnt_reg[TAP_W-1:0];
        cf_wdata = COEF_WIDTH'(default_coef(int'(cnt_reg)));
        if (cnt_reg == DL_AW'(DL_DEPTH - 1)) state_next = IDLE;
      end
      IDLE: begin
        if (coef_ok) begin
          cf_we   = 1'b1;
          cf_addr = coef_addr;
        end
        if (accept) begin
          dl_we      = 1'b1;
          dl_addr    = wr_addr;
          state_next = bypass ? OUT : MAC;
        end
      end
      MAC:     if (tap_idx == TAP_W'(NUM_TAPS - 1)) state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Delay-line RAM, read-first with registered output.
  always_ff @(posedge sck) begin
    if (dl_we) dl_mem[dl_addr] <= dl_wdata;
    x_rd <= dl_mem[dl_addr];
  end

  // Coefficient RAM, read-first with registered output.
  always_ff @(posedge sck) begin
    if (cf_we) cf_mem[cf_addr] <= cf_wdata;
    h_rd <= cf_mem[cf_addr];
  end

  // Datapath: counter, accumulator, result staging, output registers.
  // Read data lags the address by one cycle, so MAC skips tap 0's slot and
  // ROUND folds in the last product.
  always_ff @(posedge sck) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      ch_reg      <= '0;
      acc_reg     <= '0;
      res_reg     <= '0;
      sat_res_reg <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_vld     <= 1'b0;
      sat         <= 1'b0;
      coef_err    <= 1'b0;
      for (int i = 0; i < CH_SLOTS; i++) wptr_reg[i] <= '0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      out_vld  <= 1'b0;
      sat      <= 1'b0;
      case (state_reg)
        INIT: cnt_reg <= (state_next == IDLE) ? '0 : cnt_reg + DL_AW'(1);
        IDLE: begin
          cnt_reg <= '0;
          if (accept) begin
            ch_reg      <= in_ch;
            acc_reg     <= '0;
            res_reg     <= in_data;
            sat_res_reg <= 1'b0;
          end
        end
        MAC: begin
          cnt_reg <= cnt_reg + DL_AW'(1);
          if (tap_idx != '0) acc_reg <= acc_sum;
        end
        ROUND: begin
          res_reg     <= rs_y;
          sat_res_reg <= rs_sat;
        end
        OUT: begin
          out_data <= res_reg;
          out_ch   <= ch_reg;
          out_vld  <= 1'b1;
          sat      <= sat_res_reg;
          wptr_reg[ch_reg] <= (wptr_reg[ch_reg] == TAP_W'(NUM_TAPS - 1)) ?
                              '0 : wptr_reg[ch_reg] + TAP_W'(1);
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule
